// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with sub-word RMW and MEM/WB register
//
// Purpose: sits between EX/MEM and a big-endian, byte-organised data memory
// with a word-wide port. Adds byte/halfword loads (sign/zero extended) and
// byte/halfword stores (2-cycle read-modify-write), detects misaligned
// accesses, drops out-of-range accesses, and owns the MEM/WB register.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-low reset
//   mem_read_in, mem_write_in  load / store request (store wins if both set)
//   size_in, unsigned_in       00 byte, 01 half, 1x word; zero-extend loads
//   address_in, write_data_in  effective address (or ALU result), store data
//   rd_in, reg_write_in        destination register and writeback enable
//   dm_data_in                 combinational read data from data memory
//   dm_address_out             word-aligned memory address
//   dm_write_data_out          word written to memory
//   dm_mem_write_out           memory write strobe
//   dm_mem_read_out            memory read enable
//   stall_out                  holds PC, IF/ID and EX/MEM
//   wb_*                       MEM/WB pipeline register outputs
module mem_access_unit #(
  parameter int n         = 32,
  parameter int MEM_BYTES = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read_in,
  input  logic         mem_write_in,
  input  logic [1:0]   size_in,
  input  logic         unsigned_in,
  input  logic [n-1:0] address_in,
  input  logic [n-1:0] write_data_in,
  input  logic [4:0]   rd_in,
  input  logic         reg_write_in,
  input  logic [n-1:0] dm_data_in,
  output logic [n-1:0] dm_address_out,
  output logic [n-1:0] dm_write_data_out,
  output logic         dm_mem_write_out,
  output logic         dm_mem_read_out,
  output logic         stall_out,
  output logic [n-1:0] wb_data_out,
  output logic [4:0]   wb_rd_out,
  output logic         wb_reg_write_out,
  output logic         wb_misaligned_out
);

  typedef enum logic {IDLE, RMW_WRITE} state_t;

  localparam logic [n-1:0] MEM_LIMIT = n'(MEM_BYTES);

  state_t       state;
  logic [n-1:0] merge_q;

  logic         is_mem;
  logic         is_store;
  logic         is_load;
  logic         size_byte;
  logic         size_half;
  logic         size_word;
  logic         misaligned;
  logic         out_of_range;
  logic         access_ok;
  logic         sub_store;
  logic [4:0]   byte_base;
  logic [7:0]   byte_lane;
  logic [15:0]  half_lane;
  logic [n-1:0] load_value;
  logic [n-1:0] merged;

  assign dm_address_out = {address_in[n-1:2], 2'b00};

  // Access decode
  assign is_mem       = mem_read_in | mem_write_in;
  assign is_store     = mem_write_in;
  assign is_load      = mem_read_in & ~mem_write_in;
  assign size_byte    = (size_in == 2'b00);
  assign size_half    = (size_in == 2'b01);
  assign size_word    = size_in[1];
  assign misaligned   = is_mem & ((size_half & address_in[0]) |
                                  (size_word & (address_in[1:0] != 2'b00)));
  assign out_of_range = (address_in >= MEM_LIMIT);
  assign access_ok    = is_mem & ~misaligned & ~out_of_range;
  assign sub_store    = access_ok & is_store & ~size_word;

  // Big-endian lanes: byte offset k lives at bit 8*(3-k); 3-k == ~k for 2 bits
  assign byte_base = {~address_in[1:0], 3'b000};
  assign byte_lane = dm_data_in[byte_base +: 8];
  assign half_lane = address_in[1] ? dm_data_in[15:0] : dm_data_in[31:16];

  always_comb begin
    load_value = '0;
    if (out_of_range) begin
      load_value = '0;
    end else if (size_byte) begin
      load_value = {{(n-8){byte_lane[7] & ~unsigned_in}}, byte_lane};
    end else if (size_half) begin
      load_value = {{(n-16){half_lane[15] & ~unsigned_in}}, half_lane};
    end else begin
      load_value = dm_data_in;
    end
  end

  // Old word captured in cycle 1 with the addressed lane replaced
  always_comb begin
    merged = merge_q;
    if (size_byte) begin
      merged[byte_base +: 8] = write_data_in[7:0];
    end else if (address_in[1]) begin
      merged[15:0] = write_data_in[15:0];
    end else begin
      merged[31:16] = write_data_in[15:0];
    end
  end

  // Memory strobes and stall; reset masks them immediately, even mid-RMW
  always_comb begin
    dm_mem_read_out   = 1'b0;
    dm_mem_write_out  = 1'b0;
    stall_out         = 1'b0;
    dm_write_data_out = write_data_in;
    if (state == RMW_WRITE) begin
      dm_mem_write_out  = 1'b1;
      dm_write_data_out = merged;
    end else if (access_ok) begin
      if (is_store) begin
        if (size_word) begin
          dm_mem_write_out = 1'b1;
        end else begin
          stall_out       = 1'b1;
          dm_mem_read_out = 1'b1;
        end
      end else if (is_load) begin
        dm_mem_read_out = 1'b1;
      end
    end
    if (!reset) begin
      dm_mem_read_out  = 1'b0;
      dm_mem_write_out = 1'b0;
      stall_out        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      merge_q           <= '0;
      wb_data_out       <= '0;
      wb_rd_out         <= '0;
      wb_reg_write_out  <= 1'b0;
      wb_misaligned_out <= 1'b0;
    end else if (state == RMW_WRITE) begin
      state             <= IDLE;
      wb_data_out       <= '0;
      wb_rd_out         <= rd_in;
      wb_reg_write_out  <= 1'b0;
      wb_misaligned_out <= 1'b0;
    end else if (sub_store) begin
      // First RMW cycle: latch the old word, send a bubble down the pipe
      state             <= RMW_WRITE;
      merge_q           <= dm_data_in;
      wb_data_out       <= '0;
      wb_rd_out         <= '0;
      wb_reg_write_out  <= 1'b0;
      wb_misaligned_out <= 1'b0;
    end else begin
      wb_rd_out         <= rd_in;
      wb_misaligned_out <= misaligned;
      if (misaligned || is_store) begin
        wb_data_out      <= '0;
        wb_reg_write_out <= 1'b0;
      end else if (is_load) begin
        wb_data_out      <= load_value;
        wb_reg_write_out <= reg_write_in;
      end else begin
        wb_data_out      <= address_in;
        wb_reg_write_out <= reg_write_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

  localparam int MB = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, uns, reg_write;
  logic [1:0]  size;
  logic [31:0] address, write_data, dm_data;
  logic [4:0]  rd;
  logic [31:0] dm_address, dm_wdata, wb_data;
  logic        dm_write, dm_read, stall;
  logic [4:0]  wb_rd;
  logic        wb_reg_write, wb_misaligned;
  logic        clear_mem;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.n(32), .MEM_BYTES(MB)) dut (
    .clk(clk), .reset(reset),
    .mem_read_in(mem_read), .mem_write_in(mem_write),
    .size_in(size), .unsigned_in(uns),
    .address_in(address), .write_data_in(write_data),
    .rd_in(rd), .reg_write_in(reg_write),
    .dm_data_in(dm_data),
    .dm_address_out(dm_address), .dm_write_data_out(dm_wdata),
    .dm_mem_write_out(dm_write), .dm_mem_read_out(dm_read),
    .stall_out(stall),
    .wb_data_out(wb_data), .wb_rd_out(wb_rd),
    .wb_reg_write_out(wb_reg_write), .wb_misaligned_out(wb_misaligned)
  );

  // Data memory environment: big-endian bytes, combinational read
  logic [7:0] mem [0:MB-1];
  logic [9:0] ma;
  assign ma = dm_address[9:0];
  assign dm_data = (dm_address < 32'(MB)) ?
                   {mem[ma], mem[ma+10'd1], mem[ma+10'd2], mem[ma+10'd3]} : 32'h0;
  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < MB; i++) mem[i] <= 8'h00;
    end else if (dm_write && dm_address < 32'(MB)) begin
      mem[ma]       <= dm_wdata[31:24];
      mem[ma+10'd1] <= dm_wdata[23:16];
      mem[ma+10'd2] <= dm_wdata[15:8];
      mem[ma+10'd3] <= dm_wdata[7:0];
    end
  end

  // Reference memory, updated only by the model
  logic [7:0] ref_mem [0:MB-1];

  typedef struct {
    logic        r, w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] addr, wd;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] e_data;
    logic        e_mis, e_rw;
    int          e_stall, e_wr, e_rdstb;
  } vec_t;

  vec_t tbl [0:21];

  function automatic vec_t mk(logic r, logic w, logic [1:0] sz, logic u,
                              logic [31:0] addr, logic [31:0] wd, logic [4:0] rdv,
                              logic rw, logic [31:0] e_data, logic e_mis, logic e_rw,
                              int e_stall, int e_wr, int e_rdstb);
    vec_t v;
    v.r = r; v.w = w; v.sz = sz; v.u = u; v.addr = addr; v.wd = wd;
    v.rd = rdv; v.rw = rw; v.e_data = e_data; v.e_mis = e_mis; v.e_rw = e_rw;
    v.e_stall = e_stall; v.e_wr = e_wr; v.e_rdstb = e_rdstb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: byte-array memory and the access rules
  task automatic model_op(input vec_t v, output vec_t e);
    int nb;
    logic [31:0] val;
    e = v;
    nb = (v.sz == 2'b00) ? 1 : (v.sz == 2'b01) ? 2 : 4;
    e.e_data = 32'h0; e.e_mis = 1'b0; e.e_rw = 1'b0;
    e.e_stall = 0; e.e_wr = 0; e.e_rdstb = 0;
    if (!(v.r || v.w)) begin
      e.e_data = v.addr;
      e.e_rw   = v.rw;
    end else if (v.addr % nb != 0) begin
      e.e_mis = 1'b1;
    end else if (v.w) begin
      if (v.addr < MB) begin
        for (int i = 0; i < nb; i++) ref_mem[v.addr + i] = 8'(v.wd >> (8 * (nb - 1 - i)));
        e.e_wr    = 1;
        e.e_stall = (nb < 4) ? 1 : 0;
        e.e_rdstb = (nb < 4) ? 1 : 0;
      end
    end else begin
      e.e_rw = v.rw;
      if (v.addr < MB) begin
        val = 32'h0;
        for (int i = 0; i < nb; i++) val = (val << 8) | 32'(ref_mem[v.addr + i]);
        if (!v.u && nb < 4 && val[8*nb-1]) val = val | ~((32'h1 << (8 * nb)) - 1);
        e.e_data  = val;
        e.e_rdstb = 1;
      end
    end
  endtask

  task automatic run_op(input vec_t v, output int n_st, output int n_wr, output int n_rd);
    int cyc;
    logic last;
    @(negedge clk);
    mem_read = v.r; mem_write = v.w; size = v.sz; uns = v.u;
    address = v.addr; write_data = v.wd; rd = v.rd; reg_write = v.rw;
    n_st = 0; n_wr = 0; n_rd = 0; cyc = 0;
    do begin
      #1;
      n_st += int'(stall); n_wr += int'(dm_write); n_rd += int'(dm_read);
      last = stall;
      cyc++;
      if (last) @(negedge clk);
    end while (last && cyc < 4);
    @(posedge clk);
    #1;
  endtask

  task automatic check_op(input string tag, input vec_t v, input vec_t e);
    int n_st, n_wr, n_rd;
    logic [31:0] wa, mw, rw;
    run_op(v, n_st, n_wr, n_rd);
    check({tag, " stall"}, 32'(n_st), 32'(e.e_stall));
    check({tag, " wr"}, 32'(n_wr), 32'(e.e_wr));
    check({tag, " rdstb"}, 32'(n_rd), 32'(e.e_rdstb));
    check({tag, " mis"}, 32'(wb_misaligned), 32'(e.e_mis));
    check({tag, " regw"}, 32'(wb_reg_write), 32'(e.e_rw));
    if (e.e_rw) begin
      check({tag, " data"}, wb_data, e.e_data);
      check({tag, " rd"}, 32'(wb_rd), 32'(v.rd));
    end
    wa = {v.addr[31:2], 2'b00};
    if (wa < MB) begin
      mw = {mem[wa], mem[wa+1], mem[wa+2], mem[wa+3]};
      rw = {ref_mem[wa], ref_mem[wa+1], ref_mem[wa+2], ref_mem[wa+3]};
      check({tag, " memword"}, mw, rw);
    end
  endtask

  initial begin
    vec_t v, e, t;
    int n_st, n_wr, n_rd;

    for (int i = 0; i < MB; i++) ref_mem[i] = 8'h00;
    reset = 1'b0; clear_mem = 1'b1;
    // A load is presented during reset: strobes must stay low
    mem_read = 1'b1; mem_write = 1'b0; size = 2'b10; uns = 1'b0;
    address = 32'h0; write_data = 32'h0; rd = 5'd1; reg_write = 1'b1;
    repeat (2) @(negedge clk);
    check("reset dm_read", 32'(dm_read), 32'h0);
    check("reset dm_write", 32'(dm_write), 32'h0);
    check("reset stall", 32'(stall), 32'h0);
    check("reset wb_data", wb_data, 32'h0);
    check("reset wb_rd", 32'(wb_rd), 32'h0);
    check("reset wb_regw", 32'(wb_reg_write), 32'h0);
    check("reset wb_mis", 32'(wb_misaligned), 32'h0);
    mem_read = 1'b0; reg_write = 1'b0;
    clear_mem = 1'b0; reset = 1'b1;

    //         r  w  sz    u  addr          wd            rd  rw e_data        mis rw st wr rd
    tbl[0]  = mk(0, 1, 2'd2, 0, 32'h10,  32'hDEADBEEF, 5'd5, 0, 32'h0,        0, 0, 0, 1, 0);
    tbl[1]  = mk(1, 0, 2'd2, 0, 32'h10,  32'h0,        5'd6, 1, 32'hDEADBEEF, 0, 1, 0, 0, 1);
    tbl[2]  = mk(0, 1, 2'd2, 0, 32'h10,  32'h11223344, 5'd0, 0, 32'h0,        0, 0, 0, 1, 0);
    tbl[3]  = mk(0, 1, 2'd0, 0, 32'h11,  32'h000000AA, 5'd0, 0, 32'h0,        0, 0, 1, 1, 1);
    tbl[4]  = mk(1, 0, 2'd2, 0, 32'h10,  32'h0,        5'd7, 1, 32'h11AA3344, 0, 1, 0, 0, 1);
    tbl[5]  = mk(1, 0, 2'd0, 0, 32'h11,  32'h0,        5'd8, 1, 32'hFFFFFFAA, 0, 1, 0, 0, 1);
    tbl[6]  = mk(1, 0, 2'd0, 1, 32'h11,  32'h0,        5'd8, 1, 32'h000000AA, 0, 1, 0, 0, 1);
    tbl[7]  = mk(1, 0, 2'd1, 0, 32'h12,  32'h0,        5'd9, 1, 32'h00003344, 0, 1, 0, 0, 1);
    tbl[8]  = mk(0, 1, 2'd1, 0, 32'h12,  32'h12348001, 5'd0, 0, 32'h0,        0, 0, 1, 1, 1);
    tbl[9]  = mk(1, 0, 2'd1, 0, 32'h12,  32'h0,        5'd3, 1, 32'hFFFF8001, 0, 1, 0, 0, 1);
    tbl[10] = mk(1, 0, 2'd1, 1, 32'h12,  32'h0,        5'd3, 1, 32'h00008001, 0, 1, 0, 0, 1);
    tbl[11] = mk(1, 0, 2'd2, 0, 32'h12,  32'h0,        5'd4, 1, 32'h0,        1, 0, 0, 0, 0);
    tbl[12] = mk(0, 1, 2'd1, 0, 32'h13,  32'h0000FFFF, 5'd0, 0, 32'h0,        1, 0, 0, 0, 0);
    tbl[13] = mk(1, 0, 2'd2, 0, 32'h10,  32'h0,        5'd4, 1, 32'h11AA8001, 0, 1, 0, 0, 1);
    tbl[14] = mk(0, 1, 2'd2, 0, 32'h400, 32'h55555555, 5'd0, 0, 32'h0,        0, 0, 0, 0, 0);
    tbl[15] = mk(1, 0, 2'd2, 0, 32'h400, 32'h0,        5'd2, 1, 32'h0,        0, 1, 0, 0, 0);
    tbl[16] = mk(0, 0, 2'd2, 0, 32'h12345678, 32'h0,   5'd9, 1, 32'h12345678, 0, 1, 0, 0, 0);
    tbl[17] = mk(1, 1, 2'd3, 0, 32'h14,  32'h0A0B0C0D, 5'd0, 0, 32'h0,        0, 0, 0, 1, 0);
    tbl[18] = mk(1, 0, 2'd3, 0, 32'h14,  32'h0,        5'd1, 1, 32'h0A0B0C0D, 0, 1, 0, 0, 1);
    tbl[19] = mk(1, 0, 2'd0, 0, 32'h17,  32'h0,        5'd1, 1, 32'h0000000D, 0, 1, 0, 0, 1);
    tbl[20] = mk(0, 1, 2'd0, 0, 32'h13,  32'hFFFFFF80, 5'd0, 0, 32'h0,        0, 0, 1, 1, 1);
    tbl[21] = mk(1, 0, 2'd0, 0, 32'h13,  32'h0,        5'd1, 1, 32'hFFFFFF80, 0, 1, 0, 0, 1);

    for (int i = 0; i < 22; i++) begin
      model_op(tbl[i], t);
      check_op($sformatf("vec%0d", i), tbl[i], tbl[i]);
    end

    // Reset asserted asynchronously during RMW_WRITE
    v = mk(0, 1, 2'd2, 0, 32'h20, 32'hCAFEF00D, 5'd0, 0, 0, 0, 0, 0, 0, 0);
    model_op(v, e);
    check_op("sw20", v, e);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b1; size = 2'b00; uns = 1'b0;
    address = 32'h20; write_data = 32'h55; rd = 5'd0; reg_write = 1'b0;
    #1 check("rmw c1 stall", 32'(stall), 32'h1);
    @(negedge clk);
    #1 check("rmw c2 write", 32'(dm_write), 32'h1);
    #1 reset = 1'b0;
    #1 check("rmw rst write", 32'(dm_write), 32'h0);
    check("rmw rst read", 32'(dm_read), 32'h0);
    check("rmw rst stall", 32'(stall), 32'h0);
    @(posedge clk);
    #1 check("rmw rst wb_regw", 32'(wb_reg_write), 32'h0);
    check("rmw rst memword", {mem[32], mem[33], mem[34], mem[35]}, 32'hCAFEF00D);
    @(negedge clk);
    mem_write = 1'b0; write_data = 32'h0;
    #1 check("rmw rst idle stall", 32'(stall), 32'h0);
    reset = 1'b1;
    v = mk(1, 0, 2'd2, 0, 32'h20, 32'h0, 5'd11, 1, 32'hCAFEF00D, 0, 1, 0, 0, 1);
    model_op(v, e);
    check_op("lw20 after rst", v, v);

    // Randomised accesses against the model
    for (int i = 0; i < 300; i++) begin
      v.r  = 1'($urandom_range(0, 1));
      v.w  = 1'($urandom_range(0, 1));
      v.sz = 2'($urandom_range(0, 3));
      v.u  = 1'($urandom_range(0, 1));
      v.addr = ($urandom_range(0, 9) == 0) ? 32'h3F8 + 32'($urandom_range(0, 15))
                                           : 32'($urandom_range(0, 127));
      v.wd = $urandom;
      v.rd = 5'($urandom_range(0, 31));
      v.rw = 1'($urandom_range(0, 1));
      model_op(v, e);
      check_op($sformatf("rnd%0d", i), v, e);
    end

    n_st = 0;
    for (int i = 0; i < MB; i++) if (mem[i] !== ref_mem[i]) n_st++;
    check("final mem diff bytes", 32'(n_st), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit of the 32-bit MIPS pipeline, sitting between the EX/MEM pipeline register and the byte-organised, big-endian data memory.
- Adds byte and halfword loads and stores on top of the word-wide memory port, with sign or zero extension.
- Sub-word stores use a 2-cycle read-modify-write and stall the front of the pipeline for the extra cycle.
- Detects misaligned accesses and owns the MEM/WB pipeline register.

Parameters:
- n, 32, data/address width
- MEM_BYTES, 1024, data memory size in bytes; addresses at or above this are out of range

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- mem_read_in  input  1  load request from EX/MEM
- mem_write_in  input  1  store request from EX/MEM
- size_in  input  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word
- unsigned_in  input  1  1 = zero-extend loads (LBU/LHU)
- address_in  input  n  effective address, or the ALU result for non-memory instructions
- write_data_in  input  n  store data, right-justified
- rd_in  input  5  destination register
- reg_write_in  input  1  writeback enable
- dm_data_in  input  n  read data from data memory (combinational)
- dm_address_out  output  n  word-aligned address, {address_in[n-1:2],2'b00}
- dm_write_data_out  output  n  word to write to memory
- dm_mem_write_out  output  1  memory write strobe
- dm_mem_read_out  output  1  memory read enable
- stall_out  output  1  holds PC, IF/ID and EX/MEM
- wb_data_out  output  n  MEM/WB data
- wb_rd_out  output  5  MEM/WB destination register
- wb_reg_write_out  output  1  MEM/WB writeback enable
- wb_misaligned_out  output  1  MEM/WB misalignment exception flag

Behaviour:
- FSM states: IDLE, RMW_WRITE.
- Reset (reset=0, asynchronous):
  - state=IDLE; merge register = 0; all wb_* outputs = 0.
  - dm_mem_write_out, dm_mem_read_out and stall_out are forced to 0 while reset is asserted.
- Misalignment:
  - Half access with addr[0]=1, or word access with addr[1:0]≠0.
  - No memory strobes are driven.
  - The MEM/WB register captures wb_misaligned_out=1 and wb_reg_write_out=0.
  - Takes one cycle; no stall.
- Write priority: if mem_write_in and mem_read_in are both 1, the access is treated as a store.
- Byte lanes (big-endian): byte offset k occupies bits [31-8k -: 8]; halfword offset 0 occupies bits 31:16, offset 2 occupies bits 15:0.
- Load (IDLE, aligned):
  - dm_mem_read_out=1 in the same cycle.
  - The selected lane is extracted and sign- or zero-extended.
  - Result is captured into wb_data_out at the next edge with rd and reg_write.
  - Latency: one edge; no stall.
- Word store (IDLE, aligned):
  - dm_mem_write_out=1 and dm_write_data_out=write_data_in in the same cycle.
  - MEM/WB captures reg_write=0.
- Sub-word store, cycle 1 (IDLE):
  - Combinationally: stall_out=1, dm_mem_read_out=1, dm_mem_write_out=0.
  - At the edge: dm_data_in is captured into the merge register; next state RMW_WRITE; MEM/WB captures a bubble (all zero).
- Sub-word store, cycle 2 (RMW_WRITE):
  - stall_out=0, dm_mem_write_out=1.
  - dm_write_data_out = merge register with the addressed lane replaced by write_data_in[7:0] (byte) or [15:0] (half).
  - Inputs are still held by upstream during this cycle.
  - At the edge: next state IDLE; MEM/WB captures reg_write=0.
- Non-memory instruction: wb_data_out ← address_in; rd and reg_write pass through; no strobes.
- Out of range (address_in ≥ MEM_BYTES):
  - Loads return 0.
  - Stores are dropped (no strobe, no RMW).
  - Single cycle; not flagged.
- Reset mid-RMW: returns to IDLE immediately; no write is issued and the merge register is cleared.
- Timing: all strobes are combinational from state and inputs; wb_* outputs are registered only.

Test Plan:
- Word store 0xDEADBEEF to 0x10, then LW 0x10 → dm_mem_write_out=1 for one cycle, no stall; load gives wb_data_out=0xDEADBEEF one edge later.
- SB 0x000000AA to 0x11 over word 0x11223344 → stall_out=1 for one cycle; RMW_WRITE drives 0x11AA3344 with dm_mem_write_out=1; the preceding cycle is a bubble.
- LB 0x11 over 0x11AA3344 → 0xFFFFFFAA; LBU → 0x000000AA; LH 0x12 → 0x00003344.
- LW 0x12 and SH 0x13 → no strobes, wb_misaligned_out=1, wb_reg_write_out=0; no memory change.
- reset=0 asserted asynchronously during RMW_WRITE → strobes drop to 0 before the next edge; state=IDLE; memory word unchanged.
- SW to 0x400 and LW from 0x400 with MEM_BYTES=1024 → store dropped; load gives wb_data_out=0.
